// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiator: operand width and FSM states.
package mod_exp_pkg;

    localparam int unsigned W = 12;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        REDUCE = 2'd1,
        EXP    = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage : mod_exp_pkg

// File: rtl/mod_exp_mod_mult.sv
// mod_mult: interleaved shift-add modular multiplier, p = a*b mod n (requires a < n).
// Ports: clk, rst_n (async active-low), start (operands sampled this edge),
//        a, b, n (W bits), p (product, valid while ready), ready (one-cycle pulse).
// ready pulses exactly W clock edges after the edge that sampled start.
module mod_mult
    import mod_exp_pkg::*;
#(
    parameter int unsigned W = mod_exp_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] p,
    output logic         ready
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  acc_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  n_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          ready_q;

    // One MSB-first step: double, reduce, conditionally add a, reduce (W+1-bit intermediate).
    function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc, input logic [W-1:0] av,
                                             input logic [W-1:0] nv, input logic bit_v);
        logic [W:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, nv}) t = t - {1'b0, nv};
        if (bit_v) begin
            t = t + {1'b0, av};
            if (t >= {1'b0, nv}) t = t - {1'b0, nv};
        end
        return t[W-1:0];
    endfunction

    // The first step is folded into the start edge so latency is exactly W edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (start) begin
                acc_q  <= mm_step('0, a, n, b[W-1]);
                a_q    <= a;
                b_q    <= {b[W-2:0], 1'b0};
                n_q    <= n;
                cnt_q  <= CW'(W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                acc_q <= mm_step(acc_q, a_q, n_q, b_q[W-1]);
                b_q   <= {b_q[W-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    assign p     = acc_q;
    assign ready = ready_q;

endmodule : mod_mult

// File: rtl/mod_exp.sv
// mod_exp: free-running msgIn^key mod n via left-to-right square-and-multiply.
// Ports: clk, rst_n (async active-low), msgIn/key/n (W-bit operands, sampled in LOAD),
//        msgOut (registered result of last completed pass), done (one-cycle pulse on update).
// Every key bit costs a square plus a multiply slot so pass length never depends on operands.
module mod_exp
    import mod_exp_pkg::*;
#(
    parameter int unsigned W = mod_exp_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] msgIn,
    input  logic [W-1:0] key,
    input  logic [W-1:0] n,
    output logic [W-1:0] msgOut,
    output logic         done
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    state_e        state_q;
    logic [W-1:0]  key_q;
    logic [W-1:0]  n_q;
    logic [W-1:0]  base_q;
    logic [W-1:0]  result_q;
    logic [IW-1:0] bit_idx_q;
    logic          phase_q;     // 0: square in flight, 1: multiply slot in flight
    logic          start_q;
    logic [W-1:0]  mul_a_q;
    logic [W-1:0]  mul_b_q;
    logic [W-1:0]  msg_out_q;
    logic          done_q;

    logic [W-1:0]  mul_p;
    logic          mul_ready;
    logic [W-1:0]  mul_res_c;

    mod_mult #(.W(W)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_q),
        .a     (mul_a_q),
        .b     (mul_b_q),
        .n     (n_q),
        .p     (mul_p),
        .ready (mul_ready)
    );

    // Multiply slot result is kept only when the current key bit is set.
    assign mul_res_c = key_q[bit_idx_q] ? mul_p : result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            key_q     <= '0;
            n_q       <= '0;
            base_q    <= '0;
            result_q  <= '0;
            bit_idx_q <= '0;
            phase_q   <= 1'b0;
            start_q   <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            msg_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                LOAD: begin
                    key_q     <= key;
                    n_q       <= n;
                    result_q  <= W'(1);
                    bit_idx_q <= IW'(W - 1);
                    mul_a_q   <= W'(1);
                    mul_b_q   <= msgIn;
                    start_q   <= 1'b1;
                    state_q   <= REDUCE;
                end
                REDUCE: begin
                    if (mul_ready) begin
                        base_q  <= mul_p;
                        mul_a_q <= result_q;
                        mul_b_q <= result_q;
                        phase_q <= 1'b0;
                        start_q <= 1'b1;
                        state_q <= EXP;
                    end
                end
                EXP: begin
                    if (mul_ready) begin
                        if (!phase_q) begin
                            result_q <= mul_p;
                            mul_a_q  <= base_q;
                            mul_b_q  <= mul_p;
                            phase_q  <= 1'b1;
                            start_q  <= 1'b1;
                        end else begin
                            result_q <= mul_res_c;
                            if (bit_idx_q == '0) begin
                                state_q <= DONE;
                            end else begin
                                bit_idx_q <= bit_idx_q - IW'(1);
                                mul_a_q   <= mul_res_c;
                                mul_b_q   <= mul_res_c;
                                phase_q   <= 1'b0;
                                start_q   <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // Moduli 0 and 1 break the a < n precondition; their answer is 0 by definition.
                    msg_out_q <= (n_q < W'(2)) ? '0 : result_q;
                    done_q    <= 1'b1;
                    state_q   <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign msgOut = msg_out_q;
    assign done   = done_q;

endmodule : mod_exp

// File: tb/tb_mod_exp.sv
// Scoreboard bench for mod_exp: expected results are queued per pass, a monitor pops on done.
module tb_mod_exp;

    localparam int unsigned W = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] msgIn = '0;
    logic [W-1:0] key = '0;
    logic [W-1:0] n = '0;
    logic [W-1:0] msgOut;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -1;
    int first_int = -1;
    int interval;
    logic prev_done = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    mod_exp #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .msgIn  (msgIn),
        .key    (key),
        .n      (n),
        .msgOut (msgOut),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare msgOut against the scoreboard at every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_done = -1;
            prev_done = 1'b0;
        end else begin
            if (done === 1'b1) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high on consecutive cycles, required one-cycle pulse");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: msgOut=%0d with empty scoreboard", msgOut);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (msgOut !== exp_v) begin
                        errors++;
                        $display("FAIL result: msgOut=%0d expected %0d", msgOut, exp_v);
                    end
                end
                if (last_done >= 0) begin
                    interval = cyc - last_done;
                    if (first_int < 0) first_int = interval;
                    checks++;
                    if (interval != first_int || interval > 400) begin
                        errors++;
                        $display("FAIL interval: done-to-done=%0d expected %0d (max 400)", interval, first_int);
                    end
                end
                last_done = cyc;
            end
            prev_done = done;
        end
    end

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) break;
        end
        if (k == 1000) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: no done within 1000 cycles, expected a done pulse", name);
        end
    endtask

    task automatic run_vec(input int m, input int k, input int nn, input int e, input string name);
        msgIn = W'(m);
        key   = W'(k);
        n     = W'(nn);
        exp_q.push_back(W'(e));
        wait_done(name);
    endtask

    initial begin
        msgIn = W'(300);
        key   = W'(100);
        n     = W'(143);
        #12;
        checks++;
        if (msgOut !== '0) begin errors++; $display("FAIL reset_msgOut: got %0d expected 0", msgOut); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", done); end

        exp_q.push_back(W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("first");

        run_vec(300, 100, 143, 1, "repeat");
        run_vec(9, 7, 143, 48, "rsa_enc");
        run_vec(48, 103, 143, 9, "rsa_dec");
        run_vec(2, 10, 1000, 24, "pow2");
        run_vec(5, 0, 143, 1, "key0");
        run_vec(143, 0, 143, 1, "key0_base0");
        run_vec(7, 5, 1, 0, "n1");
        run_vec(7, 5, 0, 0, "n0");
        run_vec(4095, 4095, 4095, 0, "full_zero");
        run_vec(4094, 2, 4095, 1, "full_one");
        run_vec(3, 4, 2, 1, "n2");
        run_vec(4095, 1, 4094, 1, "big_base");

        // Reset in the middle of a pass: outputs clear at once, the pass is discarded.
        msgIn = W'(12);
        key   = W'(3);
        n     = W'(4095);
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (msgOut !== '0) begin errors++; $display("FAIL midreset_msgOut: got %0d expected 0", msgOut); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %0d expected 0", done); end
        repeat (3) @(negedge clk);
        exp_q.push_back(W'(1728));
        rst_n = 1'b1;
        wait_done("after_reset");

        // Inputs changed mid-pass only take effect on the next pass.
        msgIn = W'(2);
        key   = W'(10);
        n     = W'(1000);
        exp_q.push_back(W'(24));
        repeat (60) @(posedge clk);
        #1;
        msgIn = W'(9);
        key   = W'(7);
        n     = W'(143);
        wait_done("midchange_old");
        exp_q.push_back(W'(48));
        wait_done("midchange_new");

        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d results never seen, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_exp
